stdp_sweep_ctrl_h1: RTL and testbench
=====================================

STDP_SWEEP_CTRL_H1 -- requirements
Module: stdp_sweep_ctrl_h1

Interface
REQ-001 The block SHALL have parameter N_IN, default 784, giving the number of synapses swept per learning event.
REQ-002 The block SHALL have parameter W, default 24, giving the weight/delta width in Q.12 fixed point.
REQ-003 The block SHALL have parameter A_PLUS, default 0.01*4096 (41), giving the peak decrease step.
REQ-004 The block SHALL have parameter A_MINUS, default 0.012*4096 (49), giving the peak increase step.
REQ-005 The block SHALL have parameter TAU_SHIFT, default 3, giving the log2 of ticks per halving of the delta.
REQ-006 The block SHALL have parameter TIMEOUT, default N_IN+16, giving the cycles allowed from sweep start to valid_wch.
REQ-007 The block SHALL have the following ports, one per line (name, direction, width, meaning):
 clk  in  1  single clock, all logic on rising edge
 rst  in  1  synchronous active-high reset
 time_tick  in  1  one-cycle pulse per simulation timestep
 post_fire  in  1  hidden-neuron fired this cycle
 learn_req  in  1  one-cycle request to run a weight update
 learn_dir  in  1  1 = increase weights, 0 = decrease; sampled with learn_req
 valid_wch  in  1  completion pulse from weight_change_h1
 start_wch  out  1  one-cycle start pulse to weight_change_h1
 spike_hold  out  1  latched direction to weight_change_h1
 ip_select  out  10  synapse index to weight_change_h1
 del_w_plus  out  W  decrease step magnitude
 del_w_minus  out  W  increase step magnitude
 busy  out  1  high from request accept to done
 done  out  1  one-cycle completion pulse
 err_timeout  out  1  sticky watchdog flag
REQ-008 Clock and reset SHALL be exactly as decided: one clock, clk; reset rst, synchronous and active-high.

Function
REQ-009 The block SHALL keep a 16-bit dt counter: cleared by post_fire, else incremented on time_tick, saturating at 0xFFFF; post_fire SHALL win when it coincides with time_tick.
REQ-010 The FSM SHALL have states IDLE, CALC, SWEEP, WAIT and DONE.
REQ-011 In IDLE, learn_req=1 SHALL move the FSM to CALC next cycle and latch learn_dir into spike_hold; busy SHALL go high in that same next cycle.
REQ-012 learn_req while not IDLE SHALL be ignored with no queueing.
REQ-013 CALC (one cycle) SHALL compute s = dt>>TAU_SHIFT from the registered dt, which already reflects a same-cycle post_fire.
REQ-014 CALC SHALL register del_w_plus = A_PLUS>>s and del_w_minus = A_MINUS>>s, forcing each to 0 when s>=W; both values SHALL be held until the next CALC.
REQ-015 The first SWEEP cycle SHALL drive start_wch=1 and ip_select=0; start_wch SHALL be 0 at all other times.
REQ-016 In SWEEP, ip_select SHALL increment by 1 per cycle; on reaching N_IN-1 the FSM SHALL go to WAIT with ip_select held at N_IN-1.
REQ-017 ip_select SHALL never exceed N_IN-1 and SHALL never wrap during a sweep.
REQ-018 In WAIT, valid_wch=1 SHALL move the FSM to DONE, and DONE SHALL drive done=1 for one cycle, then return to IDLE with busy=0 and ip_select=0.
REQ-019 valid_wch seen in SWEEP SHALL also go to DONE after the sweep reaches N_IN-1; valid_wch in IDLE or CALC SHALL be ignored.
REQ-020 A watchdog SHALL count cycles from SWEEP entry; on reaching TIMEOUT in WAIT it SHALL set err_timeout=1 and go to DONE.
REQ-021 err_timeout SHALL remain set until the next accepted learn_req.
REQ-022 spike_hold SHALL be stable from CALC through DONE.
REQ-023 Minimum request-to-done latency SHALL be N_IN+3 cycles, given valid_wch in the first WAIT cycle.

Reset
REQ-024 With rst=1 at a clock edge, the block SHALL set FSM=IDLE, dt=0, and all outputs to 0 (start_wch, spike_hold, ip_select, del_w_plus, del_w_minus, busy, done, err_timeout).
REQ-025 Reset mid-sweep SHALL abort immediately, with no further start_wch or ip_select movement and no done pulse.
REQ-026 Reset SHALL have priority over every other input in the same cycle.

Verification (bench uses N_IN=8, TIMEOUT=24)
REQ-027 The bench SHALL check: post_fire, then 0 ticks, then learn_req, learn_dir=1 -> del_w_minus=49, del_w_plus=41, spike_hold=1, start_wch at cycle +2, ip_select 0..7 on consecutive cycles.
REQ-028 The bench SHALL check: 16 time_ticks after post_fire, then learn_req -> s=2, del_w_plus=10, del_w_minus=12.
REQ-029 The bench SHALL check: dt saturated at 0xFFFF -> s=8191>=W, both deltas 0, sweep still runs and done pulses.
REQ-030 The bench SHALL check: valid_wch withheld -> err_timeout=1 at cycle 24 after SWEEP entry, done pulses once, next learn_req clears err_timeout.
REQ-031 The bench SHALL check: second learn_req during SWEEP -> ignored, exactly one start_wch and one done.
REQ-032 The bench SHALL check: rst asserted at ip_select=4 -> next cycle all outputs 0, FSM IDLE, no done pulse.

Source files
------------

// File: rtl/stdp_sweep_ctrl_h1.sv
// rtl/stdp_sweep_ctrl_h1.sv - STDP learning-event sequencer driving weight_change_h1
//
// Purpose: tracks time since the last post-synaptic spike, turns it into an
// exponentially decayed pair of weight steps, then sweeps every synapse index
// into weight_change_h1 and waits for its completion pulse (with watchdog).
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   time_tick         one pulse per simulation timestep (advances dt)
//   post_fire         hidden neuron fired (clears dt)
//   learn_req/dir     request a weight update and its direction
//   valid_wch         completion pulse from weight_change_h1
//   start_wch         one-cycle start to weight_change_h1
//   spike_hold        latched learn direction
//   ip_select         synapse index being swept
//   del_w_plus/minus  decayed decrease / increase step magnitudes
//   busy, done        activity flag and completion pulse
//   err_timeout       sticky watchdog flag, cleared by the next accepted request
module stdp_sweep_ctrl_h1 #(
  parameter int N_IN      = 784,
  parameter int W         = 24,
  parameter int A_PLUS    = 41,
  parameter int A_MINUS   = 49,
  parameter int TAU_SHIFT = 3,
  parameter int TIMEOUT   = N_IN + 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         time_tick,
  input  logic         post_fire,
  input  logic         learn_req,
  input  logic         learn_dir,
  input  logic         valid_wch,
  output logic         start_wch,
  output logic         spike_hold,
  output logic [9:0]   ip_select,
  output logic [W-1:0] del_w_plus,
  output logic [W-1:0] del_w_minus,
  output logic         busy,
  output logic         done,
  output logic         err_timeout
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    SWEEP = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int              WD_W      = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [9:0]      IP_LAST   = 10'(N_IN - 1);
  localparam logic [W-1:0]    A_PLUS_W  = W'(A_PLUS);
  localparam logic [W-1:0]    A_MINUS_W = W'(A_MINUS);

  state_t          state_q, state_d;
  logic [15:0]     dt_q, dt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            seen_q, seen_d;
  logic            start_q, start_d;
  logic            hold_q, hold_d;
  logic [9:0]      ip_q, ip_d;
  logic [W-1:0]    plus_q, plus_d;
  logic [W-1:0]    minus_q, minus_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic [15:0]     s_w;
  logic [W-1:0]    plus_calc, minus_calc;

  // Decay by one halving per 2^TAU_SHIFT ticks; beyond W halvings the step is gone.
  always_comb begin
    s_w        = dt_q >> TAU_SHIFT;
    plus_calc  = (32'(s_w) >= W) ? '0 : (A_PLUS_W >> s_w);
    minus_calc = (32'(s_w) >= W) ? '0 : (A_MINUS_W >> s_w);
  end

  always_comb begin
    dt_d = dt_q;
    if (post_fire) begin
      dt_d = 16'd0;
    end else if (time_tick && (dt_q != 16'hFFFF)) begin
      dt_d = dt_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    seen_d  = seen_q;
    start_d = 1'b0;
    hold_d  = hold_q;
    ip_d    = ip_q;
    plus_d  = plus_q;
    minus_d = minus_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (learn_req) begin
          state_d = CALC;
          busy_d  = 1'b1;
          hold_d  = learn_dir;
          err_d   = 1'b0;
        end
      end
      CALC: begin
        state_d = SWEEP;
        plus_d  = plus_calc;
        minus_d = minus_calc;
        start_d = 1'b1;
        ip_d    = 10'd0;
        wd_d    = '0;
        seen_d  = 1'b0;
      end
      SWEEP: begin
        wd_d = wd_q + 1'b1;
        if (valid_wch) begin
          seen_d = 1'b1;
        end
        if (ip_q == IP_LAST) begin
          // An early completion is honoured only once the last index was issued.
          if (seen_q || valid_wch) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          ip_d = ip_q + 10'd1;
        end
      end
      WAIT: begin
        wd_d = wd_q + 1'b1;
        if (valid_wch) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else if (wd_q >= WD_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ip_d    = 10'd0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dt_q    <= 16'd0;
      wd_q    <= '0;
      seen_q  <= 1'b0;
      start_q <= 1'b0;
      hold_q  <= 1'b0;
      ip_q    <= 10'd0;
      plus_q  <= '0;
      minus_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dt_q    <= dt_d;
      wd_q    <= wd_d;
      seen_q  <= seen_d;
      start_q <= start_d;
      hold_q  <= hold_d;
      ip_q    <= ip_d;
      plus_q  <= plus_d;
      minus_q <= minus_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign start_wch   = start_q;
  assign spike_hold  = hold_q;
  assign ip_select   = ip_q;
  assign del_w_plus  = plus_q;
  assign del_w_minus = minus_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_stdp_sweep_ctrl_h1.sv
// tb/tb_stdp_sweep_ctrl_h1.sv - directed self-checking bench for stdp_sweep_ctrl_h1
module tb_stdp_sweep_ctrl_h1;

  localparam int N_IN    = 8;
  localparam int W       = 24;
  localparam int TIMEOUT = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         time_tick = 1'b0;
  logic         post_fire = 1'b0;
  logic         learn_req = 1'b0;
  logic         learn_dir = 1'b0;
  logic         valid_wch = 1'b0;
  logic         start_wch;
  logic         spike_hold;
  logic [9:0]   ip_select;
  logic [W-1:0] del_w_plus;
  logic [W-1:0] del_w_minus;
  logic         busy;
  logic         done;
  logic         err_timeout;

  int errors = 0;
  int checks = 0;

  stdp_sweep_ctrl_h1 #(
    .N_IN(N_IN), .W(W), .A_PLUS(41), .A_MINUS(49), .TAU_SHIFT(3), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .time_tick(time_tick), .post_fire(post_fire),
    .learn_req(learn_req), .learn_dir(learn_dir), .valid_wch(valid_wch),
    .start_wch(start_wch), .spike_hold(spike_hold), .ip_select(ip_select),
    .del_w_plus(del_w_plus), .del_w_minus(del_w_minus), .busy(busy),
    .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle(input int bound, output int n_start, output int n_done,
                             output bit timed_out);
    n_start   = 0;
    n_done    = 0;
    timed_out = 1'b1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (start_wch) n_start++;
      if (done) n_done++;
      if (!busy) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic fire_pulse();
    post_fire = 1'b1;
    step();
    post_fire = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({start_wch, spike_hold, ip_select, del_w_plus, del_w_minus, busy, done, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b hold=%b ip=%0d plus=%0d minus=%0d busy=%b done=%b err=%b want all 0",
               start_wch, spike_hold, ip_select, del_w_plus, del_w_minus, busy, done, err_timeout);
    end
    rst = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic_sweep();
    int n_start, n_done;
    bit to;
    fire_pulse();
    learn_req = 1'b1;
    learn_dir = 1'b1;
    step();
    learn_req = 1'b0;
    learn_dir = 1'b0;
    checks++;
    if (busy !== 1'b1 || spike_hold !== 1'b1 || start_wch !== 1'b0) begin
      errors++;
      $display("FAIL accept: got busy=%b hold=%b start=%b want 1 1 0", busy, spike_hold, start_wch);
    end
    step();
    checks++;
    if (start_wch !== 1'b1 || ip_select !== 10'd0) begin
      errors++;
      $display("FAIL first_sweep: got start=%b ip=%0d want 1 0", start_wch, ip_select);
    end
    checks++;
    if (del_w_minus !== 24'd49 || del_w_plus !== 24'd41) begin
      errors++;
      $display("FAIL deltas_dt0: got plus=%0d minus=%0d want 41 49", del_w_plus, del_w_minus);
    end
    for (int k = 1; k < N_IN; k++) begin
      step();
      checks++;
      if (ip_select !== 10'(k) || start_wch !== 1'b0 || spike_hold !== 1'b1) begin
        errors++;
        $display("FAIL sweep_idx: got ip=%0d start=%b hold=%b want %0d 0 1", ip_select, start_wch, spike_hold, k);
      end
    end
    step();
    checks++;
    if (ip_select !== 10'(N_IN - 1) || done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wait_hold: got ip=%0d done=%b busy=%b want %0d 0 1", ip_select, done, busy, N_IN - 1);
    end
    // First WAIT cycle: completion arrives -> done is N_IN+3 cycles after request.
    valid_wch = 1'b1;
    step();
    valid_wch = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || spike_hold !== 1'b1) begin
      errors++;
      $display("FAIL done_pulse: got done=%b busy=%b hold=%b want 1 1 1", done, busy, spike_hold);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ip_select !== 10'd0) begin
      errors++;
      $display("FAIL back_idle: got done=%b busy=%b ip=%0d want 0 0 0", done, busy, ip_select);
    end
    n_start = 0; n_done = 0; to = 1'b0;
  endtask

  task automatic test_decay();
    int n_start, n_done;
    bit to;
    fire_pulse();
    time_tick = 1'b1;
    for (int i = 0; i < 16; i++) step();
    time_tick = 1'b0;
    learn_req = 1'b1;
    learn_dir = 1'b0;
    step();
    learn_req = 1'b0;
    checks++;
    if (spike_hold !== 1'b0) begin errors++; $display("FAIL decay_hold: got %b want 0", spike_hold); end
    step();
    checks++;
    if (del_w_plus !== 24'd10 || del_w_minus !== 24'd12) begin
      errors++;
      $display("FAIL deltas_dt16: got plus=%0d minus=%0d want 10 12", del_w_plus, del_w_minus);
    end
    valid_wch = 1'b1;
    run_to_idle(40, n_start, n_done, to);
    valid_wch = 1'b0;
    checks++;
    if (to !== 1'b0 || n_done !== 1) begin
      errors++;
      $display("FAIL decay_done: got timed_out=%b dones=%0d want 0 1", to, n_done);
    end
  endtask

  task automatic test_saturate();
    int n_start, n_done;
    bit to;
    checks++;
    if (del_w_plus !== 24'd10 || del_w_minus !== 24'd12) begin
      errors++;
      $display("FAIL deltas_held: got plus=%0d minus=%0d want 10 12", del_w_plus, del_w_minus);
    end
    fire_pulse();
    time_tick = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    learn_req = 1'b1;
    learn_dir = 1'b1;
    step();
    learn_req = 1'b0;
    step();
    time_tick = 1'b0;
    checks++;
    if (del_w_plus !== '0 || del_w_minus !== '0 || start_wch !== 1'b1) begin
      errors++;
      $display("FAIL deltas_sat: got plus=%0d minus=%0d start=%b want 0 0 1", del_w_plus, del_w_minus, start_wch);
    end
    valid_wch = 1'b1;
    run_to_idle(40, n_start, n_done, to);
    valid_wch = 1'b0;
    checks++;
    if (to !== 1'b0 || n_done !== 1) begin
      errors++;
      $display("FAIL sat_done: got timed_out=%b dones=%0d want 0 1", to, n_done);
    end
  endtask

  task automatic test_timeout();
    int n_start, n_done;
    int early_err;
    bit to;
    early_err = 0;
    fire_pulse();
    learn_req = 1'b1;
    step();
    learn_req = 1'b0;
    step();
    // Now at cycle 0 of the sweep.
    for (int c = 1; c <= TIMEOUT; c++) begin
      step();
      if (c < TIMEOUT && (err_timeout !== 1'b0 || done !== 1'b0)) early_err++;
    end
    checks++;
    if (early_err !== 0) begin errors++; $display("FAIL timeout_early: got %0d early flags want 0", early_err); end
    checks++;
    if (err_timeout !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL timeout_fire: got err=%b done=%b want 1 1", err_timeout, done);
    end
    step();
    checks++;
    if (err_timeout !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: got err=%b done=%b busy=%b want 1 0 0", err_timeout, done, busy);
    end
    learn_req = 1'b1;
    step();
    learn_req = 1'b0;
    checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_clear: got err=%b busy=%b want 0 1", err_timeout, busy);
    end
    valid_wch = 1'b1;
    run_to_idle(40, n_start, n_done, to);
    valid_wch = 1'b0;
    checks++;
    if (to !== 1'b0 || n_done !== 1 || n_start !== 1) begin
      errors++;
      $display("FAIL timeout_rerun: got timed_out=%b starts=%0d dones=%0d want 0 1 1", to, n_start, n_done);
    end
  endtask

  task automatic test_back_to_back();
    int n_start, n_done, late_busy;
    bit to;
    late_busy = 0;
    learn_req = 1'b1;
    step();
    learn_req = 1'b0;
    step();
    n_start = start_wch ? 1 : 0;
    step();
    step();
    learn_req = 1'b1;
    step();
    learn_req = 1'b0;
    begin
      int s2, d2;
      valid_wch = 1'b1;
      run_to_idle(40, s2, d2, to);
      valid_wch = 1'b0;
      n_start += s2;
      n_done = d2;
    end
    checks++;
    if (to !== 1'b0 || n_start !== 1 || n_done !== 1) begin
      errors++;
      $display("FAIL b2b_counts: got timed_out=%b starts=%0d dones=%0d want 0 1 1", to, n_start, n_done);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy !== 1'b0 || start_wch !== 1'b0) late_busy++;
    end
    checks++;
    if (late_busy !== 0) begin errors++; $display("FAIL b2b_no_queue: got %0d busy cycles want 0", late_busy); end
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    learn_req = 1'b1;
    learn_dir = 1'b1;
    step();
    learn_req = 1'b0;
    learn_dir = 1'b0;
    step();
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (ip_select !== 10'd4) begin errors++; $display("FAIL mid_setup: got ip=%0d want 4", ip_select); end
    rst = 1'b1;
    valid_wch = 1'b1;
    learn_req = 1'b1;
    step();
    rst = 1'b0;
    valid_wch = 1'b0;
    learn_req = 1'b0;
    checks++;
    if ({start_wch, spike_hold, ip_select, del_w_plus, del_w_minus, busy, done, err_timeout} !== '0) begin
      errors++;
      $display("FAIL mid_reset: got start=%b hold=%b ip=%0d plus=%0d minus=%0d busy=%b done=%b err=%b want all 0",
               start_wch, spike_hold, ip_select, del_w_plus, del_w_minus, busy, done, err_timeout);
    end
    for (int i = 0; i < 12; i++) begin
      step();
      if (done !== 1'b0 || start_wch !== 1'b0 || busy !== 1'b0 || ip_select !== 10'd0) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL mid_quiet: got %0d active cycles want 0", stray); end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_decay();
    test_saturate();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
